// File: rtl/cpu24_pkg.sv
// Shared definitions for the 24-bit CPU datapath: register file geometry and
// the writeback request record carried from execute/load to the register file.
package cpu24_pkg;

  localparam int DATA_W   = 24;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Youngest-match search over the occupied entries of the writeback queue.
// Slot k is the k-th oldest entry, so the last matching slot is the youngest one.
module wbq_fwd_match
  import cpu24_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_req_t                    entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic [ADDR_W-1:0]          query,
  output logic                       hit,
  output logic [DATA_W-1:0]          data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  match;
  logic [DATA_W-1:0] cand [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] slot;
      assign slot      = rd_ptr + PTR_W'(gi);
      assign match[gi] = (CNT_W'(gi) < count) && (entries[slot].idx == query);
      assign cand[gi]  = entries[slot].data;
    end
  endgenerate

  always_comb begin
    hit  = |match;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) data = cand[k];
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue in front of the register file write port, with two
// forwarding lookups so readers can see values that have not retired yet.
module regfile_writeback_queue
  import cpu24_pkg::*;
#(
  parameter int DATA_W = cpu24_pkg::DATA_W,
  parameter int ADDR_W = cpu24_pkg::ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                     Clock,
  input  logic                     ResetN,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [ADDR_W-1:0]        InRD,
  input  logic [DATA_W-1:0]        InData,
  input  logic                     WbStall,
  input  logic                     Flush,
  output logic [ADDR_W-1:0]        RD,
  output logic [DATA_W-1:0]        WriteData,
  output logic                     RegWrite,
  input  logic [ADDR_W-1:0]        QueryRS,
  input  logic [ADDR_W-1:0]        QueryRT,
  output logic                     HitRS,
  output logic                     HitRT,
  output logic [DATA_W-1:0]        FwdRS,
  output logic [DATA_W-1:0]        FwdRT,
  output logic [$clog2(DEPTH):0]   Level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             alive_reg;
  logic             not_empty;
  logic             push;
  logic             pop;

  // alive_reg keeps InReady low until the first edge after reset release.
  assign not_empty = (count_reg != '0);
  assign InReady   = alive_reg & (count_reg != CNT_W'(DEPTH));
  assign RegWrite  = not_empty & ~WbStall & ~Flush;
  assign push      = InValid & InReady & ~Flush;
  assign pop       = RegWrite;

  assign RD        = not_empty ? mem[rd_ptr_reg].idx  : '0;
  assign WriteData = not_empty ? mem[rd_ptr_reg].data : '0;
  assign Level     = count_reg;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      alive_reg  <= 1'b0;
    end else begin
      alive_reg <= 1'b1;
      if (Flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CNT_W'(1);
          2'b01:   count_reg <= count_reg - CNT_W'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Entry storage carries no reset; only occupied slots are ever observed.
  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr_reg] <= '{idx: InRD, data: InData};
  end

  wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_rs (
    .entries (mem),
    .rd_ptr  (rd_ptr_reg),
    .count   (count_reg),
    .query   (QueryRS),
    .hit     (HitRS),
    .data    (FwdRS)
  );

  wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_rt (
    .entries (mem),
    .rd_ptr  (rd_ptr_reg),
    .count   (count_reg),
    .query   (QueryRT),
    .hit     (HitRT),
    .data    (FwdRT)
  );

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Writer-side front end for the 16 x 24-bit register file.
- Accepts writeback requests (destination, data) from the execute/load stages over a valid/ready stream and buffers them in a small in-order FIFO.
- Retires one request per cycle onto the register file write port (RD/WriteData/RegWrite).
- Exposes two combinational forwarding lookups so the read stage can see values still in flight.

Parameters:
DATA_W, 24, data width of a register
ADDR_W, 4, register index width (2**ADDR_W registers)
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
Clock  input  1  single clock, rising edge
ResetN  input  1  asynchronous active-low reset
InValid  input  1  producer has a writeback request
InReady  output  1  queue accepts request this cycle
InRD  input  ADDR_W  destination register of request
InData  input  DATA_W  value to write
WbStall  input  1  write port unavailable this cycle (shared/debug use)
Flush  input  1  discard all queued requests (pipeline squash)
RD  output  ADDR_W  register file write index (head entry)
WriteData  output  DATA_W  register file write data (head entry)
RegWrite  output  1  register file write enable
QueryRS  input  ADDR_W  forwarding lookup index A
QueryRT  input  ADDR_W  forwarding lookup index B
HitRS  output  1  a queued entry targets QueryRS
HitRT  output  1  a queued entry targets QueryRT
FwdRS  output  DATA_W  data of youngest queued entry matching QueryRS, else 0
FwdRT  output  DATA_W  data of youngest queued entry matching QueryRT, else 0
Level  output  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Storage: DEPTH x {ADDR_W idx, DATA_W data}, plus write pointer, read pointer, and a count of width $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Reset (ResetN low, async):
  - pointers and count = 0;
  - InReady=0 while reset is asserted, 1 the first cycle after release;
  - RegWrite=0, RD=0, WriteData=0, Hit*=0, Fwd*=0, Level=0.
  - Entry storage need not be cleared.
  - Reset mid-operation discards all queued writes; none reach the register file.
- InReady = (count != DEPTH). Depends on registered state only. No push-through-when-full, even if a pop occurs in the same cycle.
- Push: InValid & InReady & !Flush at a rising edge stores {InRD, InData} at the write pointer; write pointer +1.
- Pop/retire:
  - RegWrite = (count != 0) & !WbStall & !Flush, combinational from registered state.
  - RD and WriteData always show the head entry (0 when empty).
  - A rising edge with RegWrite=1 advances the read pointer. The register file captures the write on that same edge.
- Latency: a push at edge N is visible on RegWrite in the cycle after N (earliest register file update at edge N+1) when the queue was empty and not stalled.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full + pop: the pop proceeds; InReady stays 0 that cycle and rises next cycle.
- Empty: RegWrite=0; a push into an empty queue is not bypassed to the write port in the same cycle.
- WbStall high: the head holds, no pointer change on the read side; pushes continue until full.
- Flush (synchronous):
  - wins over push and pop: RegWrite forced 0, any push that cycle is discarded;
  - next cycle count=0 and both pointers = 0.
- Ordering: entries retire strictly in push order. Multiple entries to the same register retire oldest-first, so the final register file value is the youngest.
- Forwarding (combinational):
  - scan occupied entries only;
  - Hit* = any match;
  - Fwd* = data of the youngest match (closest to the write pointer).
  - The head entry being retired this cycle still counts as a hit; after the edge the register file holds the value.
  - The incoming InData is never forwarded.
- Level = count.

Decomposition:
- Shared package cpu24_pkg:
  - DATA_W=24, ADDR_W=4, NUM_REGS=16;
  - typedef wb_req_t {logic [ADDR_W-1:0] idx; logic [DATA_W-1:0] data;}.
- Natural sub-module: wbq_fwd_match, a combinational youngest-match priority search over DEPTH entries given read pointer, count and query index. Instantiate it twice (RS, RT).

Test Plan:
- Reset then idle: ResetN low mid-run with 3 entries queued → immediately RegWrite=0, Level=0; after release InReady=1 and no writes ever reach the register file.
- Single write: push {RD=5, 0x00ABCD} into empty queue → next cycle RegWrite=1, RD=5, WriteData=0x00ABCD; register 5 reads 0x00ABCD after that edge; Level returns to 0.
- Fill/backpressure: WbStall=1, push 4 entries → InReady=0, Level=4, 5th InValid ignored; drop WbStall → 4 consecutive RegWrite pulses in push order, then InReady=1.
- Forwarding youngest: with WbStall=1, push {3,0x000011}, {3,0x000022}, {7,0x000033}; QueryRS=3, QueryRT=7 → HitRS=1, FwdRS=0x000022, HitRT=1, FwdRT=0x000033; QueryRS=4 → HitRS=0, FwdRS=0.
- Simultaneous push/pop: queue with 2 entries, unstalled, push every cycle for 6 cycles → Level stays 2, all 8 writes retire in order.
- Flush: 3 entries queued, assert Flush with InValid=1 → RegWrite=0 that cycle, Level=0 next cycle, pushed entry absent, register file unchanged.
